search_scan_ctrl: RTL and testbench
===================================

SEARCH_SCAN_CTRL -- requirements
Module: search_scan_ctrl

Interface
REQ-001 The block SHALL have parameters: FRAME_W, default 64, frame width in pixels.
REQ-002 The block SHALL have parameters: FRAME_H, default 64, frame height in rows.
REQ-003 The block SHALL have parameters: WIN, default 4, window width in columns (power of two).
REQ-004 The block SHALL have parameters: AW, default 12, memory address width, with FRAME_W*FRAME_H <= 2^AW.
REQ-005 The block SHALL have ports: Clk  input  1  rising-edge clock, the only clock.
REQ-006 The block SHALL have ports: Rst_n  input  1  asynchronous active-low reset.
REQ-007 The block SHALL have ports: Start  input  1  begin a full scan, sampled in IDLE only.
REQ-008 The block SHALL have ports: Stall  input  1  hold all state, outputs frozen, MemRd forced 0.
REQ-009 The block SHALL have ports: MemAddr  output  AW  frame-memory read address.
REQ-010 The block SHALL have ports: MemRd  output  1  read strobe, one read per cycle maximum.
REQ-011 The block SHALL have ports: ColSel  output  log2(WIN)  column slot owning the current read.
REQ-012 The block SHALL have ports: DataValid  output  1  read data present this cycle (memory latency 1).
REQ-013 The block SHALL have ports: DataCol  output  log2(WIN)  column slot of the returned data.
REQ-014 The block SHALL have ports: PosDone  output  1  one-cycle pulse, all WIN columns of a position delivered.
REQ-015 The block SHALL have ports: PosX  output  8  window x of the completed position.
REQ-016 The block SHALL have ports: PosY  output  8  window y of the completed position.
REQ-017 The block SHALL have ports: Busy  output  1  scan in progress.
REQ-018 The block SHALL have ports: Done  output  1  one-cycle pulse at scan end.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH, DRAIN and FIN, and SHALL leave IDLE for FETCH on Start=1 with x=0, y=0 and slot k=0.
REQ-020 In FETCH with Stall=0, each cycle SHALL assert MemRd=1, ColSel=k and MemAddr=y*FRAME_W+x+k (AW-bit, no overflow by REQ-004), then increment k modulo WIN (time-slot sharing of the single read port).
REQ-021 On k=WIN-1, x SHALL advance by 1; at x=FRAME_W-WIN it SHALL wrap x to 0 and increment y.
REQ-022 The last read, at x=FRAME_W-WIN, y=FRAME_H-1, k=WIN-1, SHALL cause a transition to DRAIN.
REQ-023 DataValid/DataCol SHALL equal MemRd/ColSel delayed exactly one unstalled cycle.
REQ-024 PosDone SHALL pulse in the cycle DataValid=1 with DataCol=WIN-1, with PosX/PosY holding that position's x/y, registered alongside the read pipeline.
REQ-025 DRAIN SHALL last one cycle, delivering the final data and PosDone, then go to FIN; FIN SHALL pulse Done=1 for one cycle and return to IDLE.
REQ-026 Busy SHALL be 1 in FETCH, DRAIN and FIN, and 0 in IDLE.
REQ-027 Start while Busy=1 SHALL be ignored, and Start in the FIN cycle SHALL be ignored.
REQ-028 While Stall=1, state, x, y, k and pipeline registers SHALL hold, and MemRd, DataValid, PosDone and Done SHALL be 0; resuming SHALL continue with no skipped or repeated address.
REQ-029 An unstalled scan SHALL take exactly WIN*(FRAME_W-WIN+1)*FRAME_H FETCH cycles, which is 15616 at the defaults, and SHALL produce (FRAME_W-WIN+1)*FRAME_H PosDone pulses, which is 3904 at the defaults.

Reset
REQ-030 Rst_n=0 SHALL immediately force IDLE, x=y=k=0, and MemAddr, MemRd, ColSel, DataValid, DataCol, PosDone, PosX, PosY, Busy and Done all 0.
REQ-031 Reset mid-scan SHALL abandon the scan with no Done, and the block SHALL accept a new Start on the first clock after release.

Verification
REQ-032 Bench scenario: Start pulse at defaults -> addresses 0,1,2,3 then 1,2,3,4 then 2,... ; first PosDone at cycle 5 after Start with PosX=0, PosY=0.
REQ-033 Bench scenario: row wrap -> after the read at addr 63 (x=60, k=3), the next address is 64 (x=0, y=1, k=0); PosDone for x=60, y=0 follows.
REQ-034 Bench scenario: full scan -> 15616 MemRd, 3904 PosDone, last PosX=60, PosY=63, single Done, then Busy=0.
REQ-035 Bench scenario: Stall held for 10 cycles mid-position (k=2) -> MemRd=0 throughout, and the address sequence resumes at k=2 unchanged.
REQ-036 Bench scenario: Start repeated while Busy -> no restart, and the counts remain as in REQ-034.
REQ-037 Bench scenario: Rst_n low asynchronously mid-scan -> outputs 0 without a clock edge, then a new Start yields address 0.

Source files
------------

// File: rtl/search_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : search_scan_ctrl
// Description : Window search scan over a frame. The single memory read port is
//               time-shared among WIN column slots. A one-stage pipeline tracks
//               the returned data and flags each completed window position.
// Revision    : 1.0 - initial release
// ============================================================================
module search_scan_ctrl #(
  parameter int FRAME_W = 64,
  parameter int FRAME_H = 64,
  parameter int WIN     = 4,
  parameter int AW      = 12
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    Start,
  input  logic                    Stall,
  output logic [AW-1:0]           MemAddr,
  output logic                    MemRd,
  output logic [$clog2(WIN)-1:0]  ColSel,
  output logic                    DataValid,
  output logic [$clog2(WIN)-1:0]  DataCol,
  output logic                    PosDone,
  output logic [7:0]              PosX,
  output logic [7:0]              PosY,
  output logic                    Busy,
  output logic                    Done
);

  localparam int KW = $clog2(WIN);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [7:0]    x;
  logic [7:0]    y;
  logic [KW-1:0] k;
  logic          fetch_go;
  logic          last_rd;
  logic          dv_q;

  assign fetch_go = (state == S_FETCH) && !Stall;
  assign last_rd  = (x == 8'(FRAME_W - WIN)) && (y == 8'(FRAME_H - 1)) &&
                    (k == KW'(WIN - 1));

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= S_IDLE;
    end else if (!Stall) begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (Start)   state_nxt = S_FETCH;
      S_FETCH: if (last_rd) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Window position and slot counters; cleared on the final read so IDLE starts at 0
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      x <= '0;
      y <= '0;
      k <= '0;
    end else if (fetch_go) begin
      if (k == KW'(WIN - 1)) begin
        k <= '0;
        if (last_rd) begin
          x <= '0;
          y <= '0;
        end else if (x == 8'(FRAME_W - WIN)) begin
          x <= '0;
          y <= y + 8'd1;
        end else begin
          x <= x + 8'd1;
        end
      end else begin
        k <= k + 1'b1;
      end
    end
  end

  // Read-return pipeline, one cycle of memory latency
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      dv_q    <= 1'b0;
      DataCol <= '0;
      PosX    <= '0;
      PosY    <= '0;
    end else if (!Stall) begin
      dv_q    <= MemRd;
      DataCol <= ColSel;
      if (MemRd) begin
        PosX <= x;
        PosY <= y;
      end
    end
  end

  // Outputs
  always_comb begin
    MemRd     = fetch_go;
    ColSel    = k;
    MemAddr   = AW'(y) * AW'(FRAME_W) + AW'(x) + AW'(k);
    DataValid = dv_q && !Stall;
    PosDone   = dv_q && !Stall && (DataCol == KW'(WIN - 1));
    Busy      = (state != S_IDLE);
    Done      = (state == S_FIN) && !Stall;
  end

endmodule
`default_nettype wire

// File: tb/tb_search_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_search_scan_ctrl
// Description : Scoreboard bench for search_scan_ctrl at default parameters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_search_scan_ctrl;

  localparam int FW  = 64;
  localparam int FH  = 64;
  localparam int WIN = 4;
  localparam int AW  = 12;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b1;
  logic          Start = 1'b0;
  logic          Stall = 1'b0;
  logic [AW-1:0] MemAddr;
  logic          MemRd;
  logic [1:0]    ColSel;
  logic          DataValid;
  logic [1:0]    DataCol;
  logic          PosDone;
  logic [7:0]    PosX;
  logic [7:0]    PosY;
  logic          Busy;
  logic          Done;

  search_scan_ctrl #(.FRAME_W(FW), .FRAME_H(FH), .WIN(WIN), .AW(AW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Stall(Stall),
    .MemAddr(MemAddr), .MemRd(MemRd), .ColSel(ColSel),
    .DataValid(DataValid), .DataCol(DataCol), .PosDone(PosDone),
    .PosX(PosX), .PosY(PosY), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;
  int exp_addr[$];
  int exp_col[$];
  int exp_px[$];
  int exp_py[$];
  int rd_cnt = 0;
  int pd_cnt = 0;
  int done_cnt = 0;
  int last_px = 0;
  int last_py = 0;
  logic       prev_rd = 1'b0;
  logic [1:0] prev_col = 2'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_sb();
    exp_addr.delete();
    exp_col.delete();
    exp_px.delete();
    exp_py.delete();
    rd_cnt   = 0;
    pd_cnt   = 0;
    done_cnt = 0;
  endtask

  // Expected read order: rows, then window x, then slot k; one position per (x,y)
  task automatic push_scan();
    for (int yy = 0; yy < FH; yy++) begin
      for (int xx = 0; xx <= FW - WIN; xx++) begin
        for (int kk = 0; kk < WIN; kk++) begin
          exp_addr.push_back(yy * FW + xx + kk);
          exp_col.push_back(kk);
        end
        exp_px.push_back(xx);
        exp_py.push_back(yy);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_memaddr"}, MemAddr, 0);
    chk({tag, "_memrd"}, MemRd, 0);
    chk({tag, "_colsel"}, ColSel, 0);
    chk({tag, "_datavalid"}, DataValid, 0);
    chk({tag, "_datacol"}, DataCol, 0);
    chk({tag, "_posdone"}, PosDone, 0);
    chk({tag, "_posx"}, PosX, 0);
    chk({tag, "_posy"}, PosY, 0);
    chk({tag, "_busy"}, Busy, 0);
    chk({tag, "_done"}, Done, 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a read or a position
  always @(negedge Clk) begin
    if (!Rst_n) begin
      prev_rd  = 1'b0;
      prev_col = 2'd0;
    end else begin
      if (MemRd) begin
        rd_cnt++;
        if (exp_addr.size() == 0) begin
          chk("unexpected_read", 1, 0);
        end else begin
          chk("mem_addr", MemAddr, exp_addr.pop_front());
          chk("col_sel", ColSel, exp_col.pop_front());
        end
      end
      if (PosDone) begin
        pd_cnt++;
        last_px = PosX;
        last_py = PosY;
        if (exp_px.size() == 0) begin
          chk("unexpected_posdone", 1, 0);
        end else begin
          chk("pos_x", PosX, exp_px.pop_front());
          chk("pos_y", PosY, exp_py.pop_front());
        end
      end
      if (Done) done_cnt++;
      if (Stall) begin
        chk("stall_memrd", MemRd, 0);
        chk("stall_datavalid", DataValid, 0);
        chk("stall_posdone", PosDone, 0);
      end else begin
        chk("data_valid", DataValid, prev_rd);
        if (prev_rd) chk("data_col", DataCol, prev_col);
        chk("posdone_slot", PosDone, DataValid && (DataCol == 2'd3));
        prev_rd  = MemRd;
        prev_col = ColSel;
      end
    end
  end

  initial begin
    int         cyc;
    bit         stalled;
    logic [AW-1:0] saved;

    // Power-on reset
    #1 Rst_n = 1'b0;
    #1 chk_all_zero("reset");
    #20;
    @(posedge Clk);
    #3 Rst_n = 1'b1;
    tick();
    chk("idle_busy", Busy, 0);

    // Full scan with a mid-position stall and repeated Start while busy
    clear_sb();
    push_scan();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("busy_fetch", Busy, 1);
    chk("first_addr", MemAddr, 0);
    repeat (3) tick();
    chk("posdone_early", PosDone, 0);
    tick();
    chk("first_posdone", PosDone, 1);
    chk("first_posx", PosX, 0);
    chk("first_posy", PosY, 0);
    cyc = 5;
    stalled = 1'b0;
    while (cyc < 20000) begin
      if (Done) break;
      if (cyc >= 1000 && !stalled && MemRd && ColSel == 2'd2) begin
        saved = MemAddr;
        Stall = 1'b1;
        repeat (10) begin
          tick();
          cyc++;
          chk("stall_rd_hold", MemRd, 0);
          chk("stall_addr_hold", MemAddr, saved);
          chk("stall_col_hold", ColSel, 2);
        end
        Stall = 1'b0;
        stalled = 1'b1;
        #0 chk("resume_addr", MemAddr, saved);
      end
      Start = (cyc % 700 == 0);
      tick();
      cyc++;
    end
    chk("done_seen", Done, 1);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("busy_after_done", Busy, 0);
    tick();
    chk("start_in_fin_ignored", Busy, 0);
    chk("read_count", rd_cnt, 15616);
    chk("posdone_count", pd_cnt, 3904);
    chk("done_count", done_cnt, 1);
    chk("last_posx", last_px, 60);
    chk("last_posy", last_py, 63);
    chk("reads_left", exp_addr.size(), 0);
    chk("pos_left", exp_px.size(), 0);

    // Asynchronous reset mid-scan, then immediate restart
    clear_sb();
    push_scan();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (200) tick();
    chk("mid_scan_busy", Busy, 1);
    #2 Rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    chk("abort_no_done", done_cnt, 0);
    clear_sb();
    push_scan();
    @(posedge Clk);
    #3 Rst_n = 1'b1;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("restart_busy", Busy, 1);
    chk("restart_addr", MemAddr, 0);
    chk("restart_col", ColSel, 0);
    repeat (29) tick();
    chk("restart_reads", rd_cnt, 29);
    chk("restart_no_done", done_cnt, 0);

    Rst_n = 1'b0;
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
